// File: rtl/iigs_mem_pkg.sv
// iigs_mem_pkg
// Shared constants and types for the slow-RAM (E0/E1) sequencer:
//   - bank numbers for the fast banks (00/01) and the slow banks (E0/E1)
//   - SHADOW register bit positions (bit set = shadowing of that region off)
//   - address bounds of every shadowable video region
//   - state encoding of the direct-access sequencer
package iigs_mem_pkg;

    localparam logic [7:0] BANK_FAST0 = 8'h00;
    localparam logic [7:0] BANK_FAST1 = 8'h01;
    localparam logic [7:0] BANK_SLOW0 = 8'hE0;
    localparam logic [7:0] BANK_SLOW1 = 8'hE1;

    localparam int SH_TXT1   = 0;
    localparam int SH_HGR1   = 1;
    localparam int SH_HGR2   = 2;
    localparam int SH_SHR    = 3;
    localparam int SH_AUXHGR = 4;
    localparam int SH_TXT2   = 5;

    localparam logic [15:0] TXT1_LO = 16'h0400;
    localparam logic [15:0] TXT1_HI = 16'h07FF;
    localparam logic [15:0] TXT2_LO = 16'h0800;
    localparam logic [15:0] TXT2_HI = 16'h0BFF;
    localparam logic [15:0] HGR1_LO = 16'h2000;
    localparam logic [15:0] HGR1_HI = 16'h3FFF;
    localparam logic [15:0] HGR2_LO = 16'h4000;
    localparam logic [15:0] HGR2_HI = 16'h5FFF;
    localparam logic [15:0] SHR_LO  = 16'h2000;
    localparam logic [15:0] SHR_HI  = 16'h9FFF;

    // Queue entry: {bank[0], addr[15:0], data[7:0]}
    localparam int SHQ_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } dir_state_e;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/shadow_fifo.sv
// shadow_fifo
// Synchronous FIFO holding pending shadow copies for the slow RAM.
// A push and a pop in the same cycle are both honoured when full (the
// popped slot frees space for the push); a pop on an empty FIFO is ignored.
// Ports:
//   clk_sys, reset      clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data      write strobe and entry
//   i_pop               remove the head entry
//   o_data              head entry (valid when !o_empty)
//   o_full, o_empty     occupancy flags
//   o_level             number of stored entries, 0..DEPTH
module shadow_fifo #(
    parameter int WIDTH   = 25,
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == LEVEL_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_count;

    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LEVEL_W'(1);
                2'b01:   r_count <= r_count - LEVEL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shadow_ctrl.sv
// shadow_ctrl
// Owns every access to the 1 MHz slow RAM (banks E0/E1). CPU writes to the
// video regions of banks 00/01 are copied into a small queue and replayed
// into E0/E1 one per slow-RAM slot; direct CPU accesses to E0/E1 wait for
// the queue to drain and then take a slot of their own.
// Ports:
//   clk_sys, reset            clock, synchronous active-high reset
//   shadow[7:0]               SHADOW register (bit set = region not shadowed)
//   cpu_valid/we/bank/addr    CPU request, held while stall is high
//   cpu_dout                  CPU write data
//   stall                     CPU must hold the current access
//   cpu_rdata                 direct read data, valid the cycle stall drops
//   slow_ce/we/addr/din       single-cycle slow-RAM strobe and payload
//   slow_dout                 slow-RAM read data, one cycle after slow_ce
//   fifo_level                shadow queue occupancy
module shadow_ctrl
    import iigs_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SLOW_DIV   = 14
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  shadow,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        stall,
    output logic [7:0]  cpu_rdata,
    output logic        slow_ce,
    output logic        slow_we,
    output logic [16:0] slow_addr,
    output logic [7:0]  slow_din,
    input  logic [7:0]  slow_dout,
    output logic [2:0]  fifo_level
);

    localparam int CNT_W = $clog2(SLOW_DIV);

    // Slot timing
    logic [CNT_W-1:0] r_slot_cnt;
    logic             w_tick;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_slot_cnt <= '0;
        end else if (r_slot_cnt == CNT_W'(SLOW_DIV - 1)) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end
    end

    // Gated by reset so no strobe can leak out while reset is held.
    assign w_tick = (r_slot_cnt == CNT_W'(SLOW_DIV - 1)) & ~reset;

    // Shadow hit decode
    logic w_is_fast;
    logic w_bank1;
    logic w_aux_off;
    logic w_region;
    logic w_hit;
    logic w_direct;
    logic w_unused;

    assign w_is_fast = (cpu_bank == BANK_FAST0) | (cpu_bank == BANK_FAST1);
    assign w_bank1   = (cpu_bank == BANK_FAST1);
    // In bank 01 the AUXHGR bit overrides both hi-res page enables.
    assign w_aux_off = w_bank1 & shadow[SH_AUXHGR];

    assign w_region =
        (~shadow[SH_TXT1] & in_range(cpu_addr, TXT1_LO, TXT1_HI)) |
        (~shadow[SH_TXT2] & in_range(cpu_addr, TXT2_LO, TXT2_HI)) |
        (~shadow[SH_HGR1] & ~w_aux_off & in_range(cpu_addr, HGR1_LO, HGR1_HI)) |
        (~shadow[SH_HGR2] & ~w_aux_off & in_range(cpu_addr, HGR2_LO, HGR2_HI)) |
        (w_bank1 & ~shadow[SH_SHR] & in_range(cpu_addr, SHR_LO, SHR_HI));

    assign w_hit    = cpu_valid & cpu_we & w_is_fast & w_region;
    assign w_direct = cpu_valid & ((cpu_bank == BANK_SLOW0) | (cpu_bank == BANK_SLOW1));
    assign w_unused = ^shadow[7:6];

    // Shadow queue
    logic [SHQ_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_accept;
    logic             w_push;
    dir_state_e       r_state;
    dir_state_e       w_state_nxt;

    assign w_pop    = w_tick & ~w_empty & (r_state != ST_ACCESS);
    assign w_accept = ~w_full | w_pop;
    assign w_push   = w_hit & w_accept;

    shadow_fifo #(
        .WIDTH   (SHQ_W),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (3)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({cpu_bank[0], cpu_addr, cpu_dout}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Direct E0/E1 access sequencer
    logic w_dir_stall;
    logic w_issue;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_stall = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_direct) begin
                    w_dir_stall = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_dir_stall = 1'b1;
                // Queued shadow writes go first so a read sees them.
                if (w_tick & w_empty) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_dir_stall = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    logic [7:0] r_rdata;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_rdata <= slow_dout;
        end
    end

    assign cpu_rdata = r_rdata;
    assign stall     = ~reset & ((w_hit & ~w_accept) | w_dir_stall);

    // Slow-RAM strobe; pop and issue are exclusive (empty vs non-empty queue).
    always_comb begin
        slow_ce   = 1'b0;
        slow_we   = 1'b0;
        slow_addr = '0;
        slow_din  = '0;
        if (w_pop) begin
            slow_ce   = 1'b1;
            slow_we   = 1'b1;
            slow_addr = w_head[24:8];
            slow_din  = w_head[7:0];
        end else if (w_issue) begin
            slow_ce   = 1'b1;
            slow_we   = cpu_we;
            slow_addr = {cpu_bank[0], cpu_addr};
            slow_din  = cpu_dout;
        end
    end

endmodule

// File: tb/tb_shadow_ctrl.sv
// tb_shadow_ctrl
// Directed scenarios plus a randomized phase. A slow-RAM model answers reads;
// a reference memory and an expected-write queue are built from the shadow
// rules at the CPU-transaction level and compared with what reaches the RAM.
module tb_shadow_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int SLOW_DIV   = 14;
    localparam int BUDGET     = 300;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [7:0]  shadow;
    logic        cpu_valid;
    logic        cpu_we;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        stall;
    logic [7:0]  cpu_rdata;
    logic        slow_ce;
    logic        slow_we;
    logic [16:0] slow_addr;
    logic [7:0]  slow_din;
    logic [7:0]  slow_dout;
    logic [2:0]  fifo_level;

    shadow_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SLOW_DIV   (SLOW_DIV)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .shadow     (shadow),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_bank   (cpu_bank),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .stall      (stall),
        .cpu_rdata  (cpu_rdata),
        .slow_ce    (slow_ce),
        .slow_we    (slow_we),
        .slow_addr  (slow_addr),
        .slow_din   (slow_din),
        .slow_dout  (slow_dout),
        .fifo_level (fifo_level)
    );

    // Clock / reset-relative cycle count
    always #5 clk_sys = ~clk_sys;

    int n;  // cycles since the last reset edge; slots end when n % SLOW_DIV == SLOW_DIV-1
    always @(posedge clk_sys) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slow RAM model and reference memory
    logic [7:0] ram     [0:131071];
    logic [7:0] ref_mem [0:131071];

    always @(posedge clk_sys) begin
        if (slow_ce) begin
            slow_dout <= ram[slow_addr];
            if (slow_we) ram[slow_addr] <= slow_din;
        end
    end

    // Scoreboard
    int total = 0;
    int bad   = 0;
    int ce_cnt = 0;
    logic [24:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (slow_we) chk("we_needs_ce", {31'd0, slow_ce}, 32'd1);
            if (slow_ce) begin
                ce_cnt++;
                chk("slot_align", n % SLOW_DIV, SLOW_DIV - 1);
                if (slow_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", exp_q.size(), 1);
                    end else begin
                        chk("slow_write", {slow_addr, slow_din}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Reference shadow rules
    function automatic bit ref_hit(input logic [7:0] sh, input logic [7:0] bank,
                                   input logic [15:0] a);
        bit b1;
        if (bank != 8'h00 && bank != 8'h01) return 0;
        b1 = (bank == 8'h01);
        if (!sh[0] && a >= 16'h0400 && a <= 16'h07FF) return 1;
        if (!sh[5] && a >= 16'h0800 && a <= 16'h0BFF) return 1;
        if (!sh[1] && a >= 16'h2000 && a <= 16'h3FFF && !(b1 && sh[4])) return 1;
        if (!sh[2] && a >= 16'h4000 && a <= 16'h5FFF && !(b1 && sh[4])) return 1;
        if (b1 && !sh[3] && a >= 16'h2000 && a <= 16'h9FFF) return 1;
        return 0;
    endfunction

    // Driver tasks (each starts and ends at a falling edge)
    task automatic cpu_write(input logic [7:0] bank, input logic [15:0] a,
                             input logic [7:0] d, output bit first_stall,
                             output int stalls);
        bit h;
        h = ref_hit(shadow, bank, a);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_bank = bank; cpu_addr = a; cpu_dout = d;
        #1;
        first_stall = stall;
        stalls = 0;
        while (stall && stalls < BUDGET) begin
            stalls++;
            @(negedge clk_sys); #1;
        end
        if (stalls >= BUDGET) chk("write_timeout", {31'd0, stall}, 32'd0);
        if (h) begin
            exp_q.push_back({bank[0], a, d});
            ref_mem[{bank[0], a}] = d;
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        cpu_valid = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_direct(input bit we, input logic [7:0] bank, input logic [15:0] a,
                              input logic [7:0] d, output logic [7:0] rd,
                              output bit first_stall, output int stalls, output int gap);
        int last;
        if (we) begin
            exp_q.push_back({bank[0], a, d});
            ref_mem[{bank[0], a}] = d;
        end
        cpu_valid = 1'b1; cpu_we = we; cpu_bank = bank; cpu_addr = a; cpu_dout = d;
        #1;
        first_stall = stall;
        stalls = 0;
        last = -100;
        while (stall && stalls < BUDGET) begin
            if (slow_ce) last = stalls;
            stalls++;
            @(negedge clk_sys); #1;
        end
        if (stalls >= BUDGET) chk("direct_timeout", {31'd0, stall}, 32'd0);
        gap = stalls - last;
        rd = cpu_rdata;
        @(posedge clk_sys);
        @(negedge clk_sys);
        cpu_valid = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_tick();
        do @(negedge clk_sys); while (n % SLOW_DIV != SLOW_DIV - 1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_level != 3'd0) && k < BUDGET) begin
            @(negedge clk_sys);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge clk_sys);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},     {31'd0, stall},     32'd0);
        chk({tag, "_slow_ce"},   {31'd0, slow_ce},   32'd0);
        chk({tag, "_slow_we"},   {31'd0, slow_we},   32'd0);
        chk({tag, "_slow_addr"}, {15'd0, slow_addr}, 32'd0);
        chk({tag, "_slow_din"},  {24'd0, slow_din},  32'd0);
        chk({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
        chk({tag, "_level"},     {29'd0, fifo_level}, 32'd0);
    endtask

    // Directed sequence, then random traffic
    bit          fs;
    int          st;
    int          gp;
    int          lat;
    int          ce_mark;
    logic [7:0]  rd;
    logic [7:0]  bk;
    logic [15:0] ad;
    logic [15:0] bases [7];

    initial begin
        for (int i = 0; i < 131072; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bases = '{16'h0400, 16'h0800, 16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'hC000};
        reset = 1'b1; shadow = 8'h00; cpu_valid = 1'b0; cpu_we = 1'b0;
        cpu_bank = 8'h00; cpu_addr = 16'h0000; cpu_dout = 8'h00;
        repeat (3) @(negedge clk_sys);
        #1;
        check_all_zero("reset");
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: single shadowed text write
        shadow = 8'h00;
        cpu_write(8'h00, 16'h0400, 8'h5A, fs, st);
        chk("t1_no_stall", {31'd0, fs}, 32'd0);
        lat = 1;
        #1;
        while (!slow_ce && lat < 40) begin
            @(negedge clk_sys); #1;
            lat++;
        end
        chk("t1_latency", {31'd0, (lat <= SLOW_DIV + 1)}, 32'd1);
        wait_drain();

        // 2: inhibited region, then SHR-disabled bank 01 hi-res
        shadow = 8'h01;
        ce_mark = ce_cnt;
        cpu_write(8'h00, 16'h0400, 8'h11, fs, st);
        chk("t2_level", {29'd0, fifo_level}, 32'd0);
        repeat (SLOW_DIV + 2) @(negedge clk_sys);
        chk("t2_no_op", ce_cnt - ce_mark, 0);
        shadow = 8'h08;
        cpu_write(8'h01, 16'h2000, 8'h3C, fs, st);
        wait_drain();
        chk("t2_ram", {24'd0, ram[17'h12000]}, 32'h3C);

        // 3: overfill the queue right after a slot
        shadow = 8'h00;
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            cpu_write(8'h00, 16'h2000 + 16'(i), 8'hA0 + 8'(i), fs, st);
            chk("t3_no_stall", {31'd0, fs}, 32'd0);
        end
        chk("t3_level_full", {29'd0, fifo_level}, FIFO_DEPTH);
        cpu_write(8'h00, 16'h2004, 8'hA4, fs, st);
        chk("t3_stall_cycles", st, SLOW_DIV - FIFO_DEPTH);
        wait_drain();

        // 4: read behind two queued writes
        wait_tick();
        cpu_write(8'h00, 16'h2001, 8'hC3, fs, st);
        cpu_write(8'h00, 16'h2002, 8'h96, fs, st);
        cpu_direct(1'b0, 8'hE0, 16'h2001, 8'h00, rd, fs, st, gp);
        chk("t4_stall_cycles", st, 3 * SLOW_DIV);
        chk("t4_gap", gp, 2);
        chk("t4_rdata", {24'd0, rd}, 32'hC3);

        // 5: direct write then read back
        cpu_direct(1'b1, 8'hE1, 16'h1234, 8'hA7, rd, fs, st, gp);
        chk("t5_wr_stall", {31'd0, fs}, 32'd1);
        chk("t5_wr_gap", gp, 2);
        cpu_direct(1'b0, 8'hE1, 16'h1234, 8'h00, rd, fs, st, gp);
        chk("t5_rd_stall", {31'd0, fs}, 32'd1);
        chk("t5_rdata", {24'd0, rd}, 32'hA7);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    shadow = 8'($urandom());
                    bk = 8'($urandom_range(0, 1));
                    ad = bases[$urandom_range(0, 6)] + 16'($urandom_range(0, 15));
                    cpu_write(bk, ad, 8'($urandom()), fs, st);
                    if (!ref_hit(shadow, bk, ad)) chk("rnd_nohit_stall", {31'd0, fs}, 32'd0);
                end
                5, 6: begin
                    ad = 16'($urandom());
                    cpu_write(8'h02, ad, 8'($urandom()), fs, st);
                    chk("rnd_other_bank_stall", {31'd0, fs}, 32'd0);
                end
                7: begin
                    bk = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hE1;
                    ad = bases[$urandom_range(0, 2)] + 16'($urandom_range(0, 15));
                    cpu_direct(1'b1, bk, ad, 8'($urandom()), rd, fs, st, gp);
                    chk("rnd_dwr_gap", gp, 2);
                    chk("rnd_dwr_bound", {31'd0, (st <= (FIFO_DEPTH + 1) * SLOW_DIV + 2)}, 32'd1);
                end
                default: begin
                    bk = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hE1;
                    ad = bases[$urandom_range(0, 2)] + 16'($urandom_range(0, 15));
                    cpu_direct(1'b0, bk, ad, 8'h00, rd, fs, st, gp);
                    chk("rnd_drd_gap", gp, 2);
                    chk("rnd_drd_data", {24'd0, rd}, {24'd0, ref_mem[{bk[0], ad}]});
                end
            endcase
            chk("rnd_level_max", {31'd0, (fifo_level <= 3'(FIFO_DEPTH))}, 32'd1);
        end
        wait_drain();

        // 6: reset with queued writes and a waiting direct read
        shadow = 8'h00;
        wait_tick();
        cpu_write(8'h00, 16'h0401, 8'h01, fs, st);
        cpu_write(8'h00, 16'h0402, 8'h02, fs, st);
        cpu_write(8'h00, 16'h0403, 8'h03, fs, st);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_bank = 8'hE0; cpu_addr = 16'h0400;
        #1;
        chk("t6_direct_stall", {31'd0, stall}, 32'd1);
        @(negedge clk_sys);
        chk("t6_level_before", {29'd0, fifo_level}, 32'd3);
        reset = 1'b1; cpu_valid = 1'b0;
        exp_q.delete();
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        check_all_zero("t6");
        reset = 1'b0;
        ce_mark = ce_cnt;
        repeat (3 * SLOW_DIV) @(negedge clk_sys);
        chk("t6_no_op_after", ce_cnt - ce_mark, 0);
        chk("t6_level_after", {29'd0, fifo_level}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shadow_ctrl.md
Name: shadow_ctrl

Overview:
Sequences all traffic to the 128 KB 1 MHz slow RAM (banks E0/E1).
- Watches CPU writes to banks 00/01 and, per the SHADOW register ($C035), queues copies of video-region writes for E0/E1.
- Drains the queue at the slow-RAM slot rate and arbitrates direct CPU E0/E1 accesses against it.
- Stalls the CPU when the queue is full, or while a direct slow access is outstanding.

Parameters:
- FIFO_DEPTH, 4, shadow-write queue entries (power of two, ≥2).
- SLOW_DIV, 14, clk_sys cycles per slow-RAM access slot (≥3).

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- shadow  in  8  SHADOW register value; bit set = shadowing inhibited.
- cpu_valid  in  1  CPU access request; held high until stall is sampled low.
- cpu_we  in  1  request is a write.
- cpu_bank  in  8  request bank.
- cpu_addr  in  16  request address.
- cpu_dout  in  8  CPU write data.
- stall  out  1  CPU must hold the current access.
- cpu_rdata  out  8  read data for direct E0/E1 reads; valid in the cycle stall drops.
- slow_ce  out  1  slow-RAM enable.
- slow_we  out  1  slow-RAM write.
- slow_addr  out  17  {bank[0], addr}.
- slow_din  out  8  slow-RAM write data.
- slow_dout  in  8  slow-RAM read data; one-cycle synchronous latency.
- fifo_level  out  3  queue occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset values: all outputs 0; slot counter 0; FIFO empty; FSM IDLE. A reset mid-operation discards queued writes and any pending direct access.
- Slot counter: counts 0..SLOW_DIV-1 and wraps; slot_tick = (count == SLOW_DIV-1). At most one slow-RAM op is issued per tick.
- Shadow hit condition: cpu_valid & cpu_we & cpu_bank in {00, 01}, plus a region match:
  - bit0 clear, $0400-$07FF;
  - bit5 clear, $0800-$0BFF;
  - bit1 clear, $2000-$3FFF;
  - bit2 clear, $4000-$5FFF;
  - bank 01 only: bit3 clear, $2000-$9FFF;
  - bank 01 only: bit4 set inhibits the bit1/bit2 regions.
  - Bits 6-7 are ignored.
- Push: the hit entry {bank[0], addr, data} (25 bits) is pushed in the first cycle the FIFO can accept it.
  - Accept when not full, or when full and a pop occurs in the same cycle.
  - stall = hit & ~accept (combinational).
  - The CPU's own write to bank 00/01 is not blocked by this block.
- Pop: on slot_tick with the FIFO non-empty and no direct access in ACCESS, drive slow_ce=1, slow_we=1, slow_addr/slow_din from the head for exactly one cycle, and pop.
- Direct access: cpu_valid & cpu_bank in {E0, E1}. FSM states:
  - IDLE: direct request seen → WAIT; stall=1 starting the same cycle, combinationally.
  - WAIT: on slot_tick with the FIFO empty (write-before-read coherence) → ACCESS. Drive slow_ce=1, slow_we=cpu_we, slow_addr={cpu_bank[0], cpu_addr}, slow_din=cpu_dout for one cycle. A non-empty FIFO has priority at that tick.
  - ACCESS: capture slow_dout into cpu_rdata → DONE; stall=1.
  - DONE: stall=0 for one cycle, then → IDLE. The CPU completes and must change or drop the request; a new direct request in IDLE restarts the sequence.
- Shadow pushes are still accepted while the FSM is in WAIT. Direct and shadow requests never coincide because they target different banks.
- Non-shadowed, non-E0/E1 requests never stall.
- Slow-RAM strobes are single-cycle. slow_we is never asserted without slow_ce.
- Worst-case stall for a direct access: (FIFO_DEPTH+1)·SLOW_DIV + 2 cycles.

Decomposition:
- Package iigs_mem_pkg holds:
  - bank constants BANK_FAST0/1 = 8'h00/8'h01 and BANK_SLOW0/1 = 8'hE0/8'hE1;
  - SHADOW bit indices SH_TXT1, SH_HGR1, SH_HGR2, SH_SHR, SH_AUXHGR, SH_TXT2;
  - region bound constants;
  - the FSM state enum.
- One sub-module, shadow_fifo: synchronous FIFO, 25-bit wide, parameterised depth, with push/pop/full/empty/level and simultaneous push+pop at full or empty.

Test Plan:
1. shadow=00, a write to 00:0400=5A → after ≤SLOW_DIV+1 cycles, one slow-RAM write to 17'h00400 with data 5A; stall never asserted.
2. shadow=01, a write to 00:0400 → no slow-RAM op; fifo_level stays 0. Then a write to 01:2000 with shadow=08 → slot write to 17'h12000.
3. Five back-to-back writes to 00:2000..2004 with FIFO_DEPTH=4 → stall high on the fifth until the first pop tick, then accepted. Five slow writes follow in address order, SLOW_DIV apart.
4. Queue 2 shadow writes, then read E0:2001 → stall held until both writes drain. The read is issued at the third tick and cpu_rdata returns the freshly shadowed byte; stall drops exactly 2 cycles after the read strobe.
5. Write E1:1234=A7 then read E1:1234 → cpu_rdata=A7; each access is stalled until its slot.
6. Assert reset while 3 entries are queued and the FSM is in WAIT → next cycle all outputs are 0 and fifo_level=0. No slow-RAM op occurs until a new request arrives.
